// File: rtl/lsu_mem_stage_pkg.sv
// Shared load/store codes, state encodings and helpers for the LSU memory stage.
// Imported by lsu_mem_stage and lsu_mem_stage_align.
package lsu_mem_stage_pkg;

    localparam logic [2:0] LOAD_NOPE  = 3'b111;
    localparam logic [2:0] STORE_NOPE = 3'b111;

    localparam logic [2:0] INSTR_LB  = 3'b000;
    localparam logic [2:0] INSTR_LH  = 3'b001;
    localparam logic [2:0] INSTR_LW  = 3'b010;
    localparam logic [2:0] INSTR_LBU = 3'b100;
    localparam logic [2:0] INSTR_LHU = 3'b101;

    localparam logic [2:0] INSTR_SB = 3'b000;
    localparam logic [2:0] INSTR_SH = 3'b001;
    localparam logic [2:0] INSTR_SW = 3'b010;

    localparam logic REG_WR_EN  = 1'b1;
    localparam logic REG_WR_DIS = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

    // True when the access width demands stricter alignment than lane gives.
    function automatic logic is_misaligned(
        input logic [2:0] lc,
        input logic [2:0] sc,
        input logic [1:0] lane
    );
        logic half;
        logic word;
        half = (lc == INSTR_LH) || (lc == INSTR_LHU) || (sc == INSTR_SH);
        word = (lc == INSTR_LW) || (sc == INSTR_SW);
        return (half && lane[0]) || (word && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane logic: store strobe/data replication and load extract/extend.
// Ports: lane, load/store codes, store data and read data in; wstrb, wdata, load_data out.
module lsu_mem_stage_align
    import lsu_mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        lane,
    input  logic [2:0]        load_code,
    input  logic [2:0]        store_code,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Halfwords always use lane[1]; an odd lane is truncated to natural alignment.
    assign rd_byte = rdata[{lane, 3'b000} +: 8];
    assign rd_half = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        wstrb = 4'b0000;
        wdata = '0;
        unique case (store_code)
            INSTR_SB: begin
                wstrb = 4'b0001 << lane;
                wdata = DATA_W'({4{store_data[7:0]}});
            end
            INSTR_SH: begin
                wstrb = 4'b0011 << {lane[1], 1'b0};
                wdata = DATA_W'({2{store_data[15:0]}});
            end
            INSTR_SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = rdata;
        unique case (load_code)
            INSTR_LB:  load_data = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            INSTR_LBU: load_data = {{(DATA_W-8){1'b0}}, rd_byte};
            INSTR_LH:  load_data = {{(DATA_W-16){rd_half[15]}}, rd_half};
            INSTR_LHU: load_data = {{(DATA_W-16){1'b0}}, rd_half};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: single-outstanding req/ack bus master with write-back forwarding.
// Ports: ex_* from execute, mem_* data bus, wb_* to write-back, stall_req, bus_err.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise bus_err, no bus access.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [2:0]        ex_load_code,
    input  logic [2:0]        ex_store_code,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_wr_addr,
    input  logic              ex_wr_en,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              bus_err
);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [2:0]        lc_q, lc_d;
    logic [2:0]        sc_q, sc_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic              mis_q, mis_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              ex_is_ld;
    logic              ex_is_st;
    logic              ex_is_mem;
    logic              ex_mis;
    logic              timeout;
    logic              is_ld_q;
    logic              is_st_q;
    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_ldata;

    assign ex_is_ld  = ex_load_code != LOAD_NOPE;
    assign ex_is_st  = ex_store_code != STORE_NOPE;
    // Both codes set is illegal and falls back to pass-through.
    assign ex_is_mem = ex_is_ld ^ ex_is_st;

`ifdef LSU_MISALIGN_TRAP_EN
    assign ex_mis = is_misaligned(ex_load_code, ex_store_code,
                                  ex_alu_result[1:0]);
`else
    assign ex_mis = 1'b0;
`endif

    assign is_ld_q = lc_q != LOAD_NOPE;
    assign is_st_q = sc_q != STORE_NOPE;
    assign timeout = (state_q == S_WAIT) && (cnt_q == 8'(ACK_TIMEOUT));

    lsu_mem_stage_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .lane      (addr_q[1:0]),
        .load_code (lc_q),
        .store_code(sc_q),
        .store_data(sdata_q),
        .rdata     (mem_rdata),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .load_data (al_ldata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        lc_d       = lc_q;
        sc_d       = sc_q;
        wr_addr_d  = wr_addr_q;
        mis_d      = mis_q;
        wb_valid_d = 1'b0;
        wb_en_d    = REG_WR_DIS;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        stall_req  = 1'b0;
        mem_req    = 1'b0;
        bus_err    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ex_valid && ex_is_mem) begin
                    stall_req = 1'b1;
                    addr_d    = ex_alu_result[ADDR_W-1:0];
                    sdata_d   = ex_store_data;
                    lc_d      = ex_load_code;
                    sc_d      = ex_store_code;
                    wr_addr_d = ex_wr_addr;
                    cnt_d     = 8'd0;
                    mis_d     = ex_mis;
                    if (ex_mis) begin
                        state_d    = S_RESP;
                        wb_valid_d = 1'b1;
                        wb_addr_d  = ex_wr_addr;
                        wb_data_d  = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (ex_valid) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = ex_wr_en;
                    wb_addr_d  = ex_wr_addr;
                    wb_data_d  = ex_alu_result;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (timeout) begin
                    bus_err    = 1'b1;
                    state_d    = S_RESP;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = wr_addr_q;
                    wb_data_d  = '0;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        state_d    = S_RESP;
                        wb_valid_d = 1'b1;
                        wb_en_d    = is_ld_q ? REG_WR_EN : REG_WR_DIS;
                        wb_addr_d  = wr_addr_q;
                        wb_data_d  = is_ld_q ? al_ldata : '0;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
            end
            S_RESP: begin
                bus_err = mis_q;
                mis_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_we    = mem_req && is_st_q;
    assign mem_wstrb = (mem_req && is_st_q) ? al_wstrb : 4'b0000;
    assign mem_wdata = (mem_req && is_st_q) ? al_wdata : '0;

    assign wb_valid = wb_valid_q;
    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            sdata_q    <= '0;
            lc_q       <= LOAD_NOPE;
            sc_q       <= STORE_NOPE;
            wr_addr_q  <= 5'd0;
            mis_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            lc_q       <= lc_d;
            sc_q       <= sc_d;
            wr_addr_q  <= wr_addr_d;
            mis_q      <= mis_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
// Honours LSU_MISALIGN_TRAP_EN for the misalignment step.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_load_code;
    logic [2:0]  ex_store_code;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wr_addr;
    logic        ex_wr_en;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        bus_err;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_load_code (ex_load_code),
        .ex_store_code(ex_store_code),
        .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data),
        .ex_wr_addr   (ex_wr_addr),
        .ex_wr_en     (ex_wr_en),
        .stall_req    (stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .bus_err      (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        ex_load_code  = 3'b111;
        ex_store_code = 3'b111;
        ex_alu_result = 32'h0;
        ex_store_data = 32'h0;
        ex_wr_addr    = 5'd0;
        ex_wr_en      = 1'b0;
    endtask

    // Issue one load/store, ack it after wait_n silent WAIT cycles, check WB.
    task automatic mem_op(input string tag, input logic [2:0] lc,
                          input logic [2:0] sc, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int wait_n, input logic [31:0] e_addr,
                          input logic [3:0] e_strb,
                          input logic [31:0] e_wdata,
                          input logic [31:0] e_wb);
        int stalls;
        stalls        = 0;
        ex_valid      = 1'b1;
        ex_load_code  = lc;
        ex_store_code = sc;
        ex_alu_result = addr;
        ex_store_data = sd;
        ex_wr_addr    = 5'd7;
        ex_wr_en      = 1'b1;
        #1;
        if (stall_req) stalls++;
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < wait_n; i++) begin
            if (stall_req) stalls++;
            chk({tag, "/req_wait"}, mem_req, 1);
            @(negedge clk);
        end
        chk({tag, "/req"}, mem_req, 1);
        chk({tag, "/addr"}, mem_addr, e_addr);
        chk({tag, "/we"}, mem_we, (sc != 3'b111));
        if (sc != 3'b111) begin
            chk({tag, "/wstrb"}, mem_wstrb, e_strb);
            chk({tag, "/wdata"}, mem_wdata, e_wdata);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        #1;
        chk({tag, "/stall_ack"}, stall_req, 0);
        chk({tag, "/stall_cycles"}, stalls, wait_n + 1);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, "/wb_valid"}, wb_valid, 1);
        chk({tag, "/wb_en"}, wb_en, (sc == 3'b111));
        chk({tag, "/wb_addr"}, wb_addr, 7);
        if (sc == 3'b111) chk({tag, "/wb_data"}, wb_data, e_wb);
        chk({tag, "/req_resp"}, mem_req, 0);
        @(negedge clk);
        chk({tag, "/wb_idle"}, wb_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst/stall", stall_req, 0);
        chk("rst/req", mem_req, 0);
        chk("rst/wb_valid", wb_valid, 0);
        chk("rst/wb_data", wb_data, 0);
        chk("rst/bus_err", bus_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Pass-through.
        ex_valid      = 1'b1;
        ex_alu_result = 32'h1234_5678;
        ex_wr_addr    = 5'd5;
        ex_wr_en      = 1'b1;
        #1;
        chk("pass/stall", stall_req, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pass/wb_valid", wb_valid, 1);
        chk("pass/wb_en", wb_en, 1);
        chk("pass/wb_addr", wb_addr, 5);
        chk("pass/wb_data", wb_data, 32'h1234_5678);
        chk("pass/stall2", stall_req, 0);
        chk("pass/req", mem_req, 0);
        @(negedge clk);
        chk("pass/wb_clear", wb_valid, 0);

        // Stores.
        mem_op("sb", 3'b111, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 3,
               32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
        mem_op("sh", 3'b111, 3'b001, 32'h1002, 32'h1234_BEEF, 32'h0, 1,
               32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        mem_op("sw", 3'b111, 3'b010, 32'h1008, 32'hCAFE_F00D, 32'h0, 0,
               32'h1008, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Loads.
        mem_op("lb", 3'b000, 3'b111, 32'h2002, 32'h0, 32'h0080_0000, 1,
               32'h2000, 4'b0, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", 3'b100, 3'b111, 32'h2002, 32'h0, 32'h0080_0000, 1,
               32'h2000, 4'b0, 32'h0, 32'h0000_0080);
        mem_op("lh", 3'b001, 3'b111, 32'h2002, 32'h0, 32'h8001_0000, 2,
               32'h2000, 4'b0, 32'h0, 32'hFFFF_8001);
        mem_op("lhu", 3'b101, 3'b111, 32'h2002, 32'h0, 32'h8001_0000, 2,
               32'h2000, 4'b0, 32'h0, 32'h0000_8001);
        mem_op("lw0", 3'b010, 3'b111, 32'h2004, 32'h0, 32'hDEAD_BEEF, 0,
               32'h2004, 4'b0, 32'h0, 32'hDEAD_BEEF);

`ifdef LSU_MISALIGN_TRAP_EN
        ex_valid      = 1'b1;
        ex_load_code  = 3'b010;
        ex_alu_result = 32'h3001;
        ex_wr_addr    = 5'd3;
        ex_wr_en      = 1'b1;
        #1;
        chk("mis/stall", stall_req, 1);
        @(negedge clk);
        idle_inputs();
        chk("mis/req", mem_req, 0);
        chk("mis/bus_err", bus_err, 1);
        chk("mis/wb_valid", wb_valid, 1);
        chk("mis/wb_en", wb_en, 0);
        @(negedge clk);
        chk("mis/bus_err_off", bus_err, 0);
        chk("mis/wb_clear", wb_valid, 0);
`else
        mem_op("lh_odd", 3'b001, 3'b111, 32'h2003, 32'h0, 32'h8001_0000, 0,
               32'h2000, 4'b0, 32'h0, 32'hFFFF_8001);
        mem_op("lw_odd", 3'b010, 3'b111, 32'h3001, 32'h0, 32'h0BAD_CAFE, 0,
               32'h3000, 4'b0, 32'h0, 32'h0BAD_CAFE);
`endif

        // Illegal: both codes set falls back to pass-through.
        ex_valid      = 1'b1;
        ex_load_code  = 3'b010;
        ex_store_code = 3'b010;
        ex_alu_result = 32'h0000_55AA;
        ex_wr_addr    = 5'd9;
        ex_wr_en      = 1'b1;
        #1;
        chk("ill/stall", stall_req, 0);
        @(negedge clk);
        idle_inputs();
        chk("ill/req", mem_req, 0);
        chk("ill/wb_valid", wb_valid, 1);
        chk("ill/wb_data", wb_data, 32'h0000_55AA);
        chk("ill/wb_addr", wb_addr, 9);
        @(negedge clk);

        // Ack outside WAIT is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray/wb_valid", wb_valid, 0);
        chk("stray/req", mem_req, 0);

        // Timeout.
        ex_valid      = 1'b1;
        ex_load_code  = 3'b010;
        ex_alu_result = 32'h4000;
        ex_wr_addr    = 5'd4;
        ex_wr_en      = 1'b1;
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (mem_req && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("to/req_cycles", n, 255);
        chk("to/req_off", mem_req, 0);
        chk("to/bus_err", bus_err, 1);
        chk("to/wb_valid_early", wb_valid, 0);
        @(negedge clk);
        chk("to/bus_err_off", bus_err, 0);
        chk("to/wb_valid", wb_valid, 1);
        chk("to/wb_en", wb_en, 0);
        @(negedge clk);
        chk("to/wb_clear", wb_valid, 0);

        // Reset during WAIT.
        ex_valid      = 1'b1;
        ex_load_code  = 3'b010;
        ex_alu_result = 32'h5000;
        ex_wr_addr    = 5'd6;
        ex_wr_en      = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("rwait/req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rwait/req_off", mem_req, 0);
        chk("rwait/stall_off", stall_req, 0);
        chk("rwait/wb_valid", wb_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rwait/wb_after", wb_valid, 0);
        chk("rwait/req_after", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage of the pipeline CPU.
- Consumes the load/store codes, ALU result and register write-back fields produced by the decode/execute path.
- Drives a single-outstanding req/ack data-memory bus and lane-aligns, sign-extends and forwards results to write-back.
- Stalls upstream stages while a memory transaction is in flight.

Parameters:
- DATA_W, 32, data/register width.
- ADDR_W, 32, byte address width.
- ACK_TIMEOUT, 255, cycles to wait for mem_ack before aborting with bus_err (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  execute-stage result valid this cycle
- ex_load_code  in  3  LB/LH/LW/LBU/LHU funct3 encoding, or LOAD_NOPE
- ex_store_code  in  3  SB/SH/SW funct3 encoding, or STORE_NOPE
- ex_alu_result  in  DATA_W  effective address for loads/stores; pass-through value otherwise
- ex_store_data  in  DATA_W  rs2 data for stores
- ex_wr_addr  in  5  destination register
- ex_wr_en  in  1  register write enable
- stall_req  out  1  freeze IF/ID/EX
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (bits[1:0] = 0)
- mem_wstrb  out  4  byte-lane write strobes
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_ack  in  1  bus completion, single cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- wb_valid  out  1  write-back record valid
- wb_en  out  1  register write enable to WB
- wb_addr  out  5  register address to WB
- wb_data  out  DATA_W  value to write
- bus_err  out  1  one-cycle pulse on timeout (and misalignment when enabled)

Behaviour:
- Reset: state=IDLE; every output 0, including stall_req, mem_req, wb_*, bus_err and the timeout counter.
- States:
  - IDLE: accept a new instruction.
  - WAIT: mem_req held until ack or timeout.
  - RESP: drive the registered memory result to WB.
- IDLE, ex_valid, both codes NOPE: next cycle wb_valid=1, wb_data=ex_alu_result, wb_en/wb_addr copied. Latency 1, no stall.
- IDLE, ex_valid, load or store: register address, lane and code; go to WAIT.
  - stall_req=1 combinationally in the accept cycle and held through WAIT.
  - wb_valid=0 while in WAIT.
- WAIT:
  - mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata stay stable until the ack cycle.
  - Timeout counter increments each cycle.
- WAIT with mem_ack:
  - Capture and format read data; go to RESP.
  - stall_req drops in the ack cycle.
  - Same-cycle ack (ack in first WAIT cycle) is legal.
- RESP:
  - One cycle with wb_valid=1, then IDLE.
  - Loads: wb_en=1.
  - Stores: wb_en=0, wb_valid=1.
  - New ex_valid is not accepted in RESP; upstream is still frozen by the pipeline register.
- Store strobes, using lane = addr[1:0]:
  - SB: 4'b0001<<lane, wdata = {4{byte}}.
  - SH: 4'b0011<<(lane[1]*2), wdata = {2{half}}.
  - SW: 4'b1111.
- Load formatting:
  - LB/LBU: select byte by lane; sign/zero-extend to DATA_W.
  - LH/LHU: select half by lane[1]; sign/zero-extend to DATA_W.
  - LW: word unchanged.
- Timeout: counter reaches ACK_TIMEOUT with no ack → drop mem_req, pulse bus_err, RESP with wb_en=0. Counter clears on every WAIT entry.
- Both load and store codes non-NOPE: treated as illegal; pass-through path, no bus access.
- An ack arriving outside WAIT is ignored.
- rst mid-transaction: immediate return to IDLE; mem_req and stall_req drop the following edge. No write-back is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: halfword access with addr[0]=1, or word access with addr[1:0]!=0, issues no bus request. The block pulses bus_err the next cycle and produces RESP with wb_en=0 (1-cycle stall).
- Undefined: misaligned low bits are truncated to natural alignment (SH/LH use addr[1], SW/LW use lane 0). No error is raised.

Decomposition:
- Shared define.v:
  - LOAD_NOPE/STORE_NOPE (3'b111) and INSTR_LB..LHU / INSTR_SB..SW codes.
  - LSU state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - REG_WR_EN/DIS.
- Sub-module lsu_align: combinational store lane shift/strobe generation and load extract/extend, instanced once.

Test Plan:
- ex_valid, NOPE codes, alu_result=0x1234_5678, wr_addr=5 → next cycle wb_valid=1, wb_en=1, wb_addr=5, wb_data=0x1234_5678, stall_req never high.
- SB at addr 0x1003, store_data=0xAB → mem_addr=0x1000, wstrb=4'b1000, wdata=0xABAB_ABAB, mem_we=1. With ack after 3 cycles: stall_req high 4 cycles, then RESP with wb_en=0.
- LB at 0x2002, rdata=0x0080_0000 → wb_data=0xFFFF_FF80. LBU with the same stimulus → 0x0000_0080.
- LH at 0x2002, rdata=0x8001_0000 → 0xFFFF_8001. LHU with the same stimulus → 0x0000_8001.
- Load, never acked → after 255 WAIT cycles mem_req=0 and bus_err pulses one cycle; next cycle wb_valid=1 with wb_en=0.
- rst asserted during WAIT → next cycle mem_req=0, stall_req=0, no wb_valid. With LSU_MISALIGN_TRAP_EN, LW at 0x3001 → no mem_req, bus_err pulse.
